// File: rtl/bep_frame_transmit.sv
// bep_frame_transmit: assembles a 192-bit BEP thermostat frame and sends it MSB-first as a Manchester line
// Ports: clock, reset (sync, active-high); start requests a frame while idle;
//   thermostat_id/room_temp/set_temp/state are the payload, latched when start is accepted;
//   tx_out is the registered Manchester line (idle low); busy covers frame plus gap; done pulses once at the end.
// Optional: define BEP_TX_CHECKSUM_EN to replace the last frame byte with the XOR of the other 23 bytes.
module bep_frame_transmit #(
  parameter int HALF_BIT_CYCLES = 500,
  parameter int GAP_BITS = 4,
  parameter logic [31:0] PREAMBLE = 32'hAAAA_AAAA,
  parameter logic [15:0] TYPE_1 = 16'h0001,
  parameter logic [15:0] TYPE_2 = 16'h0000,
  parameter logic [31:0] CONSTANT = 32'h5A5A_0000,
  parameter logic [23:0] TAIL = 24'hFF00FF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  output logic        tx_out,
  output logic        busy,
  output logic        done
);
  localparam int GAP_CYCLES = GAP_BITS * 2 * HALF_BIT_CYCLES;
  localparam int HW = HALF_BIT_CYCLES > 1 ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0] LAST_BIT = 8'd191;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP = 2'd2;
  logic [1:0] fsm;
  logic [191:0] frame;
  logic [191:0] sh;
  logic [HW-1:0] hc;
  logic [GW-1:0] gc;
  logic [7:0] bc;
  logic phase;
  logic half_end;
  logic gap_end;
  logic last_bit;
`ifdef BEP_TX_CHECKSUM_EN
  logic [7:0] csum;
`endif
  always_comb begin
    frame = {PREAMBLE, TYPE_1, TYPE_2, CONSTANT, thermostat_id, room_temp, set_temp, state, TAIL};
`ifdef BEP_TX_CHECKSUM_EN
    csum = '0;
    for (int i = 1; i < 24; i++) csum = csum ^ frame[8*i +: 8];
    frame[7:0] = csum;
`endif
  end
  assign half_end = hc == HALF_LAST;
  assign gap_end = gc == GAP_LAST;
  assign last_bit = bc == LAST_BIT;
  // phase 0 drives the inverted bit, phase 1 the true bit, so a 1 gives a mid-bit rising edge
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm <= IDLE;
      sh <= '0;
      hc <= '0;
      gc <= '0;
      bc <= '0;
      phase <= 1'b0;
      tx_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: if (start) begin
          fsm <= SEND;
          sh <= frame;
          tx_out <= ~frame[191];
          busy <= 1'b1;
        end
        SEND: begin
          hc <= half_end ? '0 : hc + 1'b1;
          if (half_end) begin
            phase <= ~phase;
            if (!phase) tx_out <= sh[191];
            else if (last_bit) begin
              bc <= '0;
              tx_out <= 1'b0;
              if (GAP_CYCLES == 0) begin
                fsm <= IDLE;
                busy <= 1'b0;
                done <= 1'b1;
              end else fsm <= GAP;
            end else begin
              sh <= {sh[190:0], 1'b0};
              bc <= bc + 1'b1;
              tx_out <= ~sh[190];
            end
          end
        end
        GAP: begin
          gc <= gap_end ? '0 : gc + 1'b1;
          if (gap_end) begin
            fsm <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bep_frame_transmit.sv
// tb_bep_frame_transmit: scoreboard bench for bep_frame_transmit
module tb_bep_frame_transmit;
  localparam int H = 2;
  localparam int GB = 4;
  localparam int TOT = 384 * H + GB * 2 * H;
  localparam int H3 = 3;
  localparam int TOT3 = 384 * H3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  logic [31:0] thermostat_id = '0;
  logic [15:0] room_temp = '0;
  logic [15:0] set_temp = '0;
  logic [7:0] state = '0;
  logic tx_out, busy, done, tx3, busy3, done3;
  int checks = 0;
  int fails = 0;
  logic [191:0] exp_q[$];
  int mrem = 0;
  int aborts = 0;
  int aborts_seen = 0;
  int frames_seen = 0;
  bit smp [0:TOT-1];
  bit s3 [0:TOT3-1];

  always #5 clock = ~clock;

  bep_frame_transmit #(.HALF_BIT_CYCLES(H), .GAP_BITS(GB)) u_dut (
    .clock(clock), .reset(reset), .start(start), .thermostat_id(thermostat_id),
    .room_temp(room_temp), .set_temp(set_temp), .state(state),
    .tx_out(tx_out), .busy(busy), .done(done));

  bep_frame_transmit #(.HALF_BIT_CYCLES(H3), .GAP_BITS(0)) u_dut3 (
    .clock(clock), .reset(reset), .start(start3), .thermostat_id(thermostat_id),
    .room_temp(room_temp), .set_temp(set_temp), .state(state),
    .tx_out(tx3), .busy(busy3), .done(done3));

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [191:0] exp_frame(input logic [31:0] id, input logic [15:0] rt,
                                             input logic [15:0] st, input logic [7:0] s);
    logic [191:0] f = {32'hAAAA_AAAA, 16'h0001, 16'h0000, 32'h5A5A_0000, id, rt, st, s, 24'hFF00FF};
`ifdef BEP_TX_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
    for (int i = 1; i < 24; i++) x = x ^ f[8*i +: 8];
    f[7:0] = x;
`endif
    return f;
  endfunction

  task automatic set_payload(input logic [31:0] id, input logic [15:0] rt, input logic [15:0] st, input logic [7:0] s);
    thermostat_id = id;
    room_temp = rt;
    set_temp = st;
    state = s;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames_seen < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    check("frame_timeout", 1'(frames_seen >= n), 1'b1);
    @(negedge clock);
  endtask

  // reference model: acceptance and busy window, pushes the expected frame at acceptance
  initial forever begin
    @(posedge clock);
    if (reset) begin
      if (mrem != 0) begin
        void'(exp_q.pop_back());
        aborts++;
      end
      mrem = 0;
    end else if (mrem != 0) mrem--;
    else if (start) begin
      exp_q.push_back(exp_frame(thermostat_id, room_temp, set_temp, state));
      mrem = TOT;
    end
  end

  // monitor: captures tx_out while busy, decodes and scores on busy fall
  initial begin
    logic [191:0] bits;
    int viol, gap1, idx;
    logic busy_q, mb_q, mb;
    idx = 0;
    busy_q = 1'b0;
    mb_q = 1'b0;
    forever begin
      @(negedge clock);
      mb = 1'(mrem != 0);
      if (done) check("done_at_busy_fall", {busy_q, busy}, 2'b10);
      if (busy !== busy_q || mb !== mb_q) check("busy_vs_model", busy, mb);
      if (busy) begin
        if (idx < TOT) smp[idx] = tx_out;
        idx++;
      end else if (busy_q) begin
        if (done) begin
          check("busy_len", idx, TOT);
          viol = 0;
          gap1 = 0;
          bits = '0;
          for (int k = 0; k < 192; k++) begin
            logic b;
            b = smp[k*2*H + H];
            bits = {bits[190:0], b};
            for (int j = 0; j < H; j++)
              if (smp[k*2*H + j] !== !b || smp[k*2*H + H + j] !== b) viol++;
          end
          for (int j = 384 * H; j < TOT; j++) if (smp[j]) gap1++;
          check("manchester_viol", viol, 0);
          check("gap_high_cycles", gap1, 0);
          check("sb_nonempty", 1'(exp_q.size() != 0), 1'b1);
          if (exp_q.size() != 0) check("frame", bits, exp_q.pop_front());
          frames_seen++;
        end else begin
          check("abort_no_done", aborts, aborts_seen + 1);
          aborts_seen++;
        end
        idx = 0;
      end
      busy_q = busy;
      mb_q = mb;
    end
  end

  initial begin
    logic [191:0] bits;
    logic [191:0] ef;
    int n3, viol;
    repeat (3) @(negedge clock);
    check("rst_tx", tx_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy3", busy3, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    set_payload(32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("first_busy", busy, 1'b1);
    check("first_half_a", tx_out, 1'b0);
    @(negedge clock);
    check("first_half_b", tx_out, 1'b0);
    @(negedge clock);
    check("second_half", tx_out, 1'b1);
    wait_frames(1, TOT + 50);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (99) @(negedge clock);
    set_payload(32'hDEAD_BEEF, 16'h1111, 16'h2222, 8'h44);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    set_payload(32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03);
    wait_frames(2, TOT + 50);
    start = 1'b1;
    for (int c = 0; c < 3 * TOT + 100; c++) begin
      if (c % 200 == 0) set_payload($urandom, 16'($urandom), 16'($urandom), 8'($urandom));
      @(negedge clock);
    end
    start = 1'b0;
    wait_frames(6, 2 * TOT);
    set_payload(32'hCAFE_0001, 16'h00AA, 16'h0055, 8'h7E);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (199) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_tx", tx_out, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    set_payload(32'h0BAD_F00D, 16'h0123, 16'h0456, 8'h01);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_frames(7, TOT + 50);
    set_payload(32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03);
    start3 = 1'b1;
    @(negedge clock);
    start3 = 1'b0;
    n3 = 0;
    while (busy3 && n3 < TOT3 + 8) begin
      if (n3 < TOT3) s3[n3] = tx3;
      n3++;
      @(negedge clock);
    end
    check("d3_len", n3, TOT3);
    check("d3_done", done3, 1'b1);
    for (int j = 0; j < 6; j++) check("d3_first_bit", s3[j], 1'(j >= 3));
    viol = 0;
    bits = '0;
    for (int k = 0; k < 192; k++) begin
      logic b;
      b = s3[k*2*H3 + H3];
      bits = {bits[190:0], b};
      for (int j = 0; j < H3; j++)
        if (s3[k*2*H3 + j] !== !b || s3[k*2*H3 + H3 + j] !== b) viol++;
    end
    check("d3_manchester", viol, 0);
    ef = exp_frame(32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03);
    check("d3_frame", bits, ef);
    check("d3_tail3", bits[7:0], ef[7:0]);
    @(negedge clock);
    check("d3_done_pulse", done3, 1'b0);
    check("sb_drained", exp_q.size(), 0);
    check("frames_total", frames_seen, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
